// File: rtl/limbus_sysid_checker_if.sv
// Avalon-MM read-only bundle between the sysid checker (master)
// and the limbus system-ID slave.
interface limbus_sysid_checker_if;
    logic        av_address;
    logic        av_read;
    logic        av_waitrequest;
    logic [31:0] av_readdata;

    modport master (
        output av_address,
        output av_read,
        input  av_waitrequest,
        input  av_readdata
    );

    modport slave (
        input  av_address,
        input  av_read,
        output av_waitrequest,
        output av_readdata
    );
endinterface

// File: rtl/limbus_sysid_checker.sv
// Reads sysid words 0/1 after reset or on request and checks them
// against expected constants, with a per-access stall timeout.
module limbus_sysid_checker #(
    parameter logic [31:0] EXP_ID         = 32'd1,
    parameter logic [31:0] EXP_TIMESTAMP  = 32'd1384067151,
    parameter bit          AUTO_START     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    limbus_sysid_checker_if.master        av,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          id_mismatch,
    output logic                          ts_mismatch,
    output logic                          timeout,
    output logic [31:0]                   sys_id,
    output logic [31:0]                   sys_timestamp
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, EVAL, DONE} state_t;

    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_t      state, state_d;
    logic        auto_q, auto_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;
    logic        rd_q, rd_d;
    logic        addr_q, addr_d;
    logic        done_d, pass_d, idm_d, tsm_d, to_d;
    logic [31:0] id_d, ts_d;
    logic        expired;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    // Stall that would be the TIMEOUT_CYCLES-th in a row aborts the access
    assign expired = av.av_waitrequest && (cnt_inc == TO_LIM);

    assign av.av_read    = rd_q;
    assign av.av_address = addr_q;
    assign busy = (state == RD_ID) || (state == RD_TS) || (state == EVAL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            auto_q        <= AUTO_START;
            cnt_q         <= '0;
            rd_q          <= 1'b0;
            addr_q        <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            id_mismatch   <= 1'b0;
            ts_mismatch   <= 1'b0;
            timeout       <= 1'b0;
            sys_id        <= '0;
            sys_timestamp <= '0;
        end else begin
            state         <= state_d;
            auto_q        <= auto_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            done          <= done_d;
            pass          <= pass_d;
            id_mismatch   <= idm_d;
            ts_mismatch   <= tsm_d;
            timeout       <= to_d;
            sys_id        <= id_d;
            sys_timestamp <= ts_d;
        end
    end

    always_comb begin
        state_d = state;
        auto_d  = auto_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        done_d  = done;
        pass_d  = pass;
        idm_d   = id_mismatch;
        tsm_d   = ts_mismatch;
        to_d    = timeout;
        id_d    = sys_id;
        ts_d    = sys_timestamp;
        unique case (state)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = RD_ID;
                    auto_d  = 1'b0;
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    addr_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                end
            end
            RD_ID: begin
                if (!av.av_waitrequest) begin
                    id_d    = av.av_readdata;
                    state_d = RD_TS;
                    addr_d  = 1'b1;
                    cnt_d   = '0;
                end else if (expired) begin
                    rd_d    = 1'b0;
                    to_d    = 1'b1;
                    idm_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            RD_TS: begin
                if (!av.av_waitrequest) begin
                    ts_d    = av.av_readdata;
                    rd_d    = 1'b0;
                    state_d = EVAL;
                end else if (expired) begin
                    rd_d    = 1'b0;
                    to_d    = 1'b1;
                    tsm_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
            end
            EVAL: begin
                idm_d   = (sys_id != EXP_ID);
                tsm_d   = (sys_timestamp != EXP_TIMESTAMP);
                pass_d  = (sys_id == EXP_ID) && (sys_timestamp == EXP_TIMESTAMP);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_limbus_sysid_checker.sv
// Scoreboard bench for limbus_sysid_checker: directed checks with
// hand-computed results, timeouts and reset behaviour.
module tb_limbus_sysid_checker;

    localparam logic [31:0] TS = 32'd1384067151;

    logic clock;
    logic rst_a, start_a;
    logic busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
    logic [31:0] sid_a, sts_a;
    logic rst_b, start_b, wr_b;
    logic busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
    logic [31:0] sid_b, sts_b;

    limbus_sysid_checker_if ifa ();
    limbus_sysid_checker_if ifb ();

    limbus_sysid_checker #(
        .AUTO_START     (1'b1),
        .TIMEOUT_CYCLES (8)
    ) dut_a (
        .clock         (clock),
        .reset_n       (rst_a),
        .start         (start_a),
        .av            (ifa.master),
        .busy          (busy_a),
        .done          (done_a),
        .pass          (pass_a),
        .id_mismatch   (idm_a),
        .ts_mismatch   (tsm_a),
        .timeout       (to_a),
        .sys_id        (sid_a),
        .sys_timestamp (sts_a)
    );

    limbus_sysid_checker #(
        .AUTO_START (1'b0)
    ) dut_b (
        .clock         (clock),
        .reset_n       (rst_b),
        .start         (start_b),
        .av            (ifb.master),
        .busy          (busy_b),
        .done          (done_b),
        .pass          (pass_b),
        .id_mismatch   (idm_b),
        .ts_mismatch   (tsm_b),
        .timeout       (to_b),
        .sys_id        (sid_b),
        .sys_timestamp (sts_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc++;

    // slave model for dut_a: wait_cfg stall cycles per word, stuck address stalls forever
    int wait_cfg = 0;
    int stuck = -1;
    int wcnt;
    logic [31:0] id_val = 32'd1;
    logic [31:0] ts_val = TS;

    assign ifa.av_waitrequest = ifa.av_read &&
        ((stuck == int'(ifa.av_address)) || (wcnt < wait_cfg));
    assign ifa.av_readdata = ifa.av_address ? ts_val : id_val;

    always @(posedge clock or negedge rst_a) begin
        if (!rst_a) wcnt <= 0;
        else if (ifa.av_read && ifa.av_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    assign ifb.av_waitrequest = ifb.av_read && wr_b;
    assign ifb.av_readdata = ifb.av_address ? TS : 32'd1;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        pass;
        logic        idm;
        logic        tsm;
        logic        to;
        logic [31:0] id;
        logic [31:0] ts;
        int          lat;
        int          rd;
        int          t0;
    } exp_t;

    exp_t sbq[$];

    task automatic push(string nm, logic p, logic im, logic tm, logic t,
                        logic [31:0] eid, logic [31:0] ets, int lat, int rd);
        exp_t e;
        e.name = nm; e.pass = p; e.idm = im; e.tsm = tm; e.to = t;
        e.id = eid; e.ts = ets; e.lat = lat; e.rd = rd; e.t0 = cyc;
        sbq.push_back(e);
    endtask

    // monitor: one result per rising edge of done
    logic done_prev = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_addr = 1'b0;
    int rdcnt = 0;

    always @(negedge clock) begin
        exp_t e;
        if (!rst_a) begin
            rdcnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (ifa.av_read) rdcnt++;
            if (ifa.av_read && prev_stall)
                chk("addr_stable", 64'(ifa.av_address), 64'(prev_addr));
            prev_stall = ifa.av_read && ifa.av_waitrequest;
            prev_addr = ifa.av_address;
            if (done_a && !done_prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 64'(done_a), 64'(1'b0));
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_pass"}, 64'(pass_a), 64'(e.pass));
                    chk({e.name, "_idm"}, 64'(idm_a), 64'(e.idm));
                    chk({e.name, "_tsm"}, 64'(tsm_a), 64'(e.tsm));
                    chk({e.name, "_timeout"}, 64'(to_a), 64'(e.to));
                    chk({e.name, "_sys_id"}, 64'(sid_a), 64'(e.id));
                    chk({e.name, "_sys_ts"}, 64'(sts_a), 64'(e.ts));
                    chk({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
                    chk({e.name, "_rd_cycles"}, 64'(rdcnt), 64'(e.rd));
                    chk({e.name, "_busy"}, 64'(busy_a), 64'(1'b0));
                end
                rdcnt = 0;
            end
        end
        done_prev = done_a;
    end

    task automatic drain(int lim);
        int n = 0;
        while (sbq.size() != 0 && n < lim) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", 64'(sbq.size()), 64'(0));
            sbq.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic run(string nm, logic [31:0] idv, logic [31:0] tsv, int w, int st,
                       logic p, logic im, logic tm, logic t,
                       logic [31:0] eid, logic [31:0] ets, int lat, int rd);
        id_val = idv; ts_val = tsv; wait_cfg = w; stuck = st;
        push(nm, p, im, tm, t, eid, ets, lat, rd);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        drain(60);
    endtask

    initial begin
        rst_a = 1'b0; start_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; wr_b = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs",
            {ifa.av_read, ifa.av_address, busy_a, done_a, pass_a, idm_a, tsm_a, to_a},
            64'd0);
        chk("reset_sys_id", sid_a, 64'd0);
        chk("reset_sys_ts", sts_a, 64'd0);

        // auto-start after reset release
        push("auto", 1, 0, 0, 0, 32'd1, TS, 4, 2);
        rst_a = 1'b1;
        drain(60);

        run("id_bad", 32'd2, TS, 0, -1, 0, 1, 0, 0, 32'd2, TS, 4, 2);
        run("waits3", 32'd1, TS, 3, -1, 1, 0, 0, 0, 32'd1, TS, 10, 8);
        run("ts_stuck", 32'd1, 32'hDEAD_BEEF, 0, 1, 0, 0, 1, 1, 32'd1, TS, 10, 9);
        run("ts_bad", 32'd1, TS + 32'd1, 0, -1, 0, 0, 1, 0, 32'd1, TS + 32'd1, 4, 2);
        run("id_stuck", 32'd7, TS, 0, 0, 0, 1, 0, 1, 32'd1, TS + 32'd1, 9, 8);

        // starts during RD_TS and in DONE are ignored
        id_val = 32'd2; ts_val = TS; wait_cfg = 0; stuck = -1;
        push("ign_first", 0, 1, 0, 0, 32'd2, TS, 4, 2);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        chk("done_held_idle", {done_a, busy_a}, 64'b10);
        id_val = 32'd1;
        push("restart", 1, 0, 0, 0, 32'd1, TS, 4, 2);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        chk("entry_clear", {busy_a, done_a, pass_a, idm_a, tsm_a, to_a}, 64'b100000);
        drain(60);

        // dut_b: no auto start, async reset mid RD_ID
        rst_b = 1'b1;
        repeat (3) @(negedge clock);
        chk("b_no_auto", {busy_b, ifb.av_read, done_b}, 64'd0);
        wr_b = 1'b1;
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        chk("b_rd_id", {busy_b, ifb.av_read, ifb.av_address}, 64'b110);
        @(negedge clock);
        #2 rst_b = 1'b0;
        #1;
        chk("b_async_reset",
            {ifb.av_read, ifb.av_address, busy_b, done_b, pass_b, idm_b, tsm_b, to_b},
            64'd0);
        chk("b_reset_regs", {sid_b, sts_b}, 64'd0);
        @(negedge clock);
        rst_b = 1'b1;
        wr_b = 1'b0;
        repeat (3) @(negedge clock);
        chk("b_idle_after", {busy_b, ifb.av_read, done_b}, 64'd0);
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        repeat (3) @(negedge clock);
        chk("b_done", {done_b, pass_b, idm_b, tsm_b, to_b}, 64'b11000);
        chk("b_words", {sid_b, sts_b}, {32'd1, TS});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
